mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/risc16_pkg.sv | 29 ++
 rtl/arb_tag_pipe.sv | 40 ++++
 rtl/mem_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/risc16_pkg.sv
// Shared types and constants for the risc16 memory subsystem.
//   req_id_t   : which requester owns a memory transaction (fetch or data)
//   WE_*       : d_we encodings (none/read, word, even byte, odd byte)
//   mem_cmd_t  : one cycle of shared-memory command
package risc16_pkg;

    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned DATA_W   = 16;
    localparam int unsigned WE_W     = 2;
    localparam int unsigned STREAK_W = 4;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_t;

    localparam logic [WE_W-1:0] WE_NONE = 2'b00;
    localparam logic [WE_W-1:0] WE_WORD = 2'b11;
    localparam logic [WE_W-1:0] WE_EVEN = 2'b01;
    localparam logic [WE_W-1:0] WE_ODD  = 2'b10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              oe;
        logic [WE_W-1:0]   we;
        logic [DATA_W-1:0] dout;
    } mem_cmd_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Read-tag delay line: carries (valid, requester id) of each granted read
// DEPTH cycles so the returning m_din can be steered to the right port.
//   clk, rst            : clock, async active-high reset (clears all valids)
//   in_valid, in_id     : tag entering in the grant cycle
//   out_valid, out_id   : tag leaving exactly DEPTH cycles later
module arb_tag_pipe
    import risc16_pkg::*;
#(
    parameter int unsigned DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    in_valid,
    input  req_id_t in_id,
    output logic    out_valid,
    output req_id_t out_id
);

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] id_q;

    // Shift register; stage 0 captures the grant-cycle tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            id_q    <= '0;
        end else begin
            valid_q[0] <= in_valid;
            id_q[0]    <= in_id;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                valid_q[i] <= valid_q[i-1];
                id_q[i]    <= id_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[DEPTH-1];
    assign out_id    = req_id_t'(id_q[DEPTH-1]);

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter onto one pipelined shared memory.
// Data wins ties until it has taken D_BURST_MAX grants in a row while fetch
// waits; then fetch gets one slot. Reads return MEM_LAT cycles after grant.
//   clk, rst                         : clock, async active-high reset
//   i_req/i_addr -> i_gnt            : fetch request and combinational grant
//   i_rvalid/i_rdata                 : fetch read return
//   d_req/d_addr/d_we/d_wdata -> d_gnt : data request and combinational grant
//   d_rvalid/d_rdata                 : data read return
//   m_addr/m_oe/m_we/m_dout          : memory command in the grant cycle
//   m_din                            : memory read data, MEM_LAT cycles later
module mem_arbiter
    import risc16_pkg::*;
#(
    parameter int unsigned MEM_LAT     = 1,
    parameter int unsigned D_BURST_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [WE_W-1:0]   d_we,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_oe,
    output logic [WE_W-1:0]   m_we,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(D_BURST_MAX);

    logic [STREAK_W-1:0] d_streak;
    logic [STREAK_W-1:0] d_streak_next;
    logic                grant_i;
    logic                grant_d;
    mem_cmd_t            cmd;
    logic                rd_valid;
    req_id_t             rd_id;
    logic                ret_valid;
    req_id_t             ret_id;

    // Streak register: consecutive data grants taken while fetch was waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_streak <= '0;
        end else begin
            d_streak <= d_streak_next;
        end
    end

    // Arbitration; gated by rst so grants drop the instant reset asserts.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                if (d_streak == STREAK_MAX) begin
                    grant_i = 1'b1;
                end else begin
                    grant_d = 1'b1;
                end
            end else begin
                grant_i = i_req;
                grant_d = d_req;
            end
        end
    end

    // Streak only grows while fetch is actually waiting; saturates at the cap.
    always_comb begin
        d_streak_next = d_streak;
        if (!i_req || grant_i) begin
            d_streak_next = '0;
        end else if (grant_d && (d_streak < STREAK_MAX)) begin
            d_streak_next = d_streak + STREAK_W'(1);
        end
    end

    // Memory command from the granted requester; all-zero when idle.
    always_comb begin
        cmd = '0;
        if (grant_i) begin
            cmd.addr = i_addr;
            cmd.oe   = 1'b1;
        end else if (grant_d) begin
            cmd.addr = d_addr;
            cmd.oe   = (d_we == WE_NONE);
            cmd.we   = d_we;
            cmd.dout = d_wdata;
        end
    end

    assign rd_valid = grant_i || (grant_d && (d_we == WE_NONE));
    assign rd_id    = grant_d ? REQ_D : REQ_I;

    arb_tag_pipe #(
        .DEPTH (MEM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_valid),
        .in_id     (rd_id),
        .out_valid (ret_valid),
        .out_id    (ret_id)
    );

    assign i_gnt    = grant_i;
    assign d_gnt    = grant_d;
    assign m_addr   = cmd.addr;
    assign m_oe     = cmd.oe;
    assign m_we     = cmd.we;
    assign m_dout   = cmd.dout;

    // Returning data steered by the tag; rdata is zero when not valid.
    assign i_rvalid = ret_valid && (ret_id == REQ_I);
    assign d_rvalid = ret_valid && (ret_id == REQ_D);
    assign i_rdata  = i_rvalid ? m_din : '0;
    assign d_rdata  = d_rvalid ? m_din : '0;

endmodule
